// File: rtl/vga_frame_flip_ctrl.sv
// Frame-synchronous double-buffer controller: vsync sync/edge detect, Avalon-MM regs, tear-free flips.
// Latency: readdata 1 cycle; vs_in boundary to fb_base/FRONT update 3 edges, irq one edge later.
// Backpressure: none; slave always accepts, flip requests beyond one outstanding are dropped.
module vga_frame_flip_ctrl #(
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter logic [31:0] BUF0_RESET    = 32'h0000_0000,
  parameter logic [31:0] BUF1_RESET    = 32'h0004_B000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        vs_in,
  output logic [31:0] fb_base,
  output logic        irq
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [2:0] A_BUF0   = 3'd0;
  localparam logic [2:0] A_BUF1   = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_EVENT  = 3'd4;
  localparam logic [2:0] A_FRAMES = 3'd5;

  state_t      state, state_next;
  logic        commit;
  logic        vs_norm;
  logic        s1, s2, s3;
  logic        frame_edge;
  logic        wr;
  logic        flip_wr;
  logic        front, front_next;
  logic        irq_en;
  logic [1:0]  event_q;
  logic [1:0]  event_set, event_clr;
  logic [31:0] buf0, buf1;
  logic [31:0] frames;
  logic [31:0] rd_mux;

  // vsync normalised to active-high so a boundary is always a rising edge of s2
  assign vs_norm    = VS_ACTIVE_LOW ? ~vs_in : vs_in;
  assign frame_edge = s2 & ~s3;

  assign wr      = chipselect & ~write_n;
  assign flip_wr = wr && (address == A_CTRL) && writedata[0];

  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= vs_norm;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // flip FSM state register; reset discards any pending request
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // flip FSM next state: a request seen in an edge cycle waits for the next edge
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (flip_wr) state_next = PENDING;
      end
      PENDING: begin
        if (frame_edge) begin
          state_next = IDLE;
          commit     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign front_next = front ^ commit;

  // front selector and displayed base only move on a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      front   <= 1'b0;
      fb_base <= BUF0_RESET;
    end else begin
      front <= front_next;
      if (frame_edge) fb_base <= front_next ? buf1 : buf0;
    end
  end

  // buffer base and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      buf0   <= BUF0_RESET;
      buf1   <= BUF1_RESET;
      irq_en <= 1'b0;
    end else if (wr) begin
      case (address)
        A_BUF0:  buf0   <= writedata;
        A_BUF1:  buf1   <= writedata;
        A_CTRL:  irq_en <= writedata[1];
        default: ;
      endcase
    end
  end

  assign event_set = {commit, frame_edge};
  assign event_clr = (wr && (address == A_EVENT)) ? writedata[1:0] : 2'b00;

  // sticky events; a set in the same cycle as its clear is kept
  always_ff @(posedge clk) begin
    if (reset) event_q <= 2'b00;
    else       event_q <= (event_q & ~event_clr) | event_set;
  end

  // frame counter; a CPU write beats a coincident increment
  always_ff @(posedge clk) begin
    if (reset)                              frames <= 32'd0;
    else if (wr && (address == A_FRAMES))   frames <= 32'd0;
    else if (frame_edge)                    frames <= frames + 32'd1;
  end

  // read mux over the current register contents
  always_comb begin
    rd_mux = 32'd0;
    case (address)
      A_BUF0:   rd_mux = buf0;
      A_BUF1:   rd_mux = buf1;
      A_CTRL:   rd_mux = {30'd0, irq_en, 1'b0};
      A_STATUS: rd_mux = {29'd0, s2, (state == PENDING), front};
      A_EVENT:  rd_mux = {30'd0, event_q};
      A_FRAMES: rd_mux = frames;
      default:  rd_mux = 32'd0;
    endcase
  end

  // registered read data and level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_en & (|event_q);
    end
  end

endmodule

// File: tb/tb_vga_frame_flip_ctrl.sv
// Directed bench for vga_frame_flip_ctrl: register access, flip commit timing, events, irq, counter.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: not applicable; every access completes in one cycle.
module tb_vga_frame_flip_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        vs_in;
  logic [31:0] fb_base;
  logic        irq;

  int n_checks;
  int n_pass;
  logic [31:0] rd;

  vga_frame_flip_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .vs_in      (vs_in),
    .fb_base    (fb_base),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  // assert vsync (active low) and advance to just after edge N+2
  task automatic vs_pulse();
    vs_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic vs_release();
    vs_in = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    vs_in      = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_fb_base", fb_base, 32'h0000_0000);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick();
    bus_rd(3'd0, rd); chk("rst_buf0", rd, 32'h0000_0000);
    bus_rd(3'd1, rd); chk("rst_buf1", rd, 32'h0004_B000);
    bus_rd(3'd2, rd); chk("rst_ctrl", rd, 32'd0);
    bus_rd(3'd3, rd); chk("rst_status", rd, 32'd0);
    bus_rd(3'd4, rd); chk("rst_event", rd, 32'd0);
    bus_rd(3'd5, rd); chk("rst_frames", rd, 32'd0);
    bus_rd(3'd6, rd); chk("rst_addr6", rd, 32'd0);
    chk("rst_fb_base2", fb_base, 32'd0);
    chk("rst_irq2", {31'd0, irq}, 32'd0);

    // first flip
    bus_wr(3'd1, 32'h0010_0000);
    bus_wr(3'd2, 32'h1);
    bus_rd(3'd3, rd); chk("flip1_pending", rd, 32'h2);
    vs_in = 1'b0;
    repeat (2) tick();
    chk("flip1_fb_before", fb_base, 32'h0);
    tick();
    chk("flip1_fb_after", fb_base, 32'h0010_0000);
    bus_rd(3'd3, rd); chk("flip1_status", rd, 32'h5);
    bus_rd(3'd4, rd); chk("flip1_event", rd, 32'h3);
    vs_release();

    // second flip back to BUF0
    bus_wr(3'd2, 32'h1);
    vs_pulse();
    chk("flip2_fb", fb_base, 32'h0);
    vs_release();
    bus_rd(3'd3, rd); chk("flip2_status", rd, 32'h0);
    bus_rd(3'd5, rd); chk("flip2_frames", rd, 32'd2);

    // interrupt timing and clear
    bus_wr(3'd4, 32'h3);
    bus_wr(3'd2, 32'h2);
    bus_rd(3'd4, rd); chk("irq_event_clr", rd, 32'h0);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    vs_pulse();
    chk("irq_n2", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_n3", {31'd0, irq}, 32'd1);
    bus_wr(3'd4, 32'h1);
    tick();
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    vs_release();

    // W1C in the frame_edge cycle keeps FRAME
    vs_in = 1'b0;
    repeat (2) tick();
    bus_wr(3'd4, 32'h1);
    bus_rd(3'd4, rd); chk("w1c_race_event", rd, 32'h1);
    chk("w1c_race_irq", {31'd0, irq}, 32'd1);
    vs_release();
    bus_wr(3'd4, 32'h3);
    bus_wr(3'd2, 32'h0);

    // flip write in the frame_edge cycle commits one boundary later
    bus_wr(3'd0, 32'h0020_0000);
    vs_in = 1'b0;
    repeat (2) tick();
    bus_wr(3'd2, 32'h1);
    chk("edge_flip_no_swap", fb_base, 32'h0020_0000);
    bus_rd(3'd3, rd); chk("edge_flip_status", rd, 32'h6);
    vs_release();
    vs_pulse();
    chk("edge_flip_swap", fb_base, 32'h0010_0000);
    bus_rd(3'd3, rd); chk("edge_flip_status2", rd, 32'h5);
    vs_release();

    // two requests before one boundary give a single swap
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd2, 32'h1);
    bus_rd(3'd3, rd); chk("dbl_flip_pending", rd, 32'h3);
    vs_pulse();
    chk("dbl_flip_fb", fb_base, 32'h0020_0000);
    vs_release();
    vs_pulse();
    chk("dbl_flip_no_queue", fb_base, 32'h0020_0000);
    bus_rd(3'd3, rd); chk("dbl_flip_status", rd, 32'h4);
    vs_release();

    // frame counter wrap and write/edge race
    force dut.frames = 32'hFFFF_FFFF;
    tick();
    release dut.frames;
    tick();
    bus_rd(3'd5, rd); chk("frames_preload", rd, 32'hFFFF_FFFF);
    vs_pulse();
    bus_rd(3'd5, rd); chk("frames_wrap", rd, 32'h0);
    vs_release();
    vs_pulse();
    bus_rd(3'd5, rd); chk("frames_inc", rd, 32'h1);
    vs_release();
    vs_in = 1'b0;
    repeat (2) tick();
    bus_wr(3'd5, 32'h0000_1234);
    bus_rd(3'd5, rd); chk("frames_wr_race", rd, 32'h0);
    vs_release();

    // reset while pending with vsync asserted
    bus_wr(3'd2, 32'h3);
    bus_rd(3'd3, rd); chk("pre_rst_pending", rd, 32'h2);
    vs_in = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst2_fb_base", fb_base, 32'h0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    bus_rd(3'd3, rd); chk("rst2_status", rd, 32'h4);
    bus_rd(3'd4, rd); chk("rst2_event", rd, 32'h1);
    bus_rd(3'd5, rd); chk("rst2_frames", rd, 32'h1);
    bus_rd(3'd2, rd); chk("rst2_ctrl", rd, 32'h0);
    chk("rst2_fb_base2", fb_base, 32'h0);
    vs_release();
    bus_rd(3'd5, rd); chk("rst2_single_edge", rd, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_flip_ctrl.md
# vga_frame_flip_ctrl

Frame-synchronous double-buffer controller for the VGA path. It synchronises the raw VGA vertical-sync input and detects the start of each vsync pulse. It presents the active (front) framebuffer base address to the pixel fetch logic, and commits CPU-requested buffer swaps only at a frame boundary so the display never tears. It is an Avalon-MM slave on the system interconnect, with a level interrupt for frame and flip events.

## Interface
- VS_ACTIVE_LOW, 1: 1 = a frame boundary is the falling edge of vs_in; 0 = the rising edge.
- BUF0_RESET, 32'h0000_0000: reset value of the BUF0 base register.
- BUF1_RESET, 32'h0004_B000: reset value of the BUF1 base register.

- clk  in  1  system clock; all logic on its rising edge; one clock only.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- vs_in  in  1  asynchronous VGA vsync.
- fb_base  out  32  front-buffer base address to the pixel fetch logic; registered.
- irq  out  1  level interrupt.

## Operation
- Synchroniser and edge detect:
  - vs_in is normalised to active-high (inverted when VS_ACTIVE_LOW=1).
  - It passes through two flops (s1, s2), then one history flop (s3).
  - frame_edge = s2 & ~s3.
- Registers (word addresses):
  - 0 BUF0 (RW, 32).
  - 1 BUF1 (RW, 32).
  - 2 CTRL (RW):
    - bit0 FLIP: write 1 = request a swap; reads 0.
    - bit1 IRQ_EN.
  - 3 STATUS (RO):
    - bit0 FRONT: 0 = BUF0 is front.
    - bit1 PENDING.
    - bit2 VS: synchronised s2 level.
  - 4 EVENT (W1C):
    - bit0 FRAME: set on every frame_edge.
    - bit1 FLIPPED: set when a swap commits.
  - 5 FRAMES (R; any write clears): 32-bit frame_edge counter, wraps 0xFFFF_FFFF -> 0.
  - 6, 7: read 0; writes ignored.
- FSM has two states, IDLE and PENDING:
  - IDLE + FLIP write -> PENDING.
  - PENDING + frame_edge -> IDLE; FRONT toggles; EVENT.FLIPPED is set.
  - PENDING + FLIP write: no effect; requests are not queued.
  - A FLIP write in the same cycle as a frame_edge while in IDLE goes to PENDING. It commits at the next frame_edge, not the current one.
- fb_base is reloaded on every frame_edge from the register selected by the post-commit FRONT. CPU writes to BUF0/BUF1 therefore reach the display only at a frame boundary.
- irq = IRQ_EN & (EVENT.FRAME | EVENT.FLIPPED); it is registered.
- Simultaneous events:
  - EVENT: a set in the same cycle as a W1C clear of the same bit wins the set.
  - FRAMES: a write in the same cycle as a frame_edge wins, so FRAMES = 0.
- Reset:
  - readdata=0, irq=0, fb_base=BUF0_RESET.
  - FRONT=0, FSM=IDLE, CTRL=0, EVENT=0, FRAMES=0.
  - s1/s2/s3 = 0.
  - A pending flip is discarded.
  - If vs_in is already asserted at reset release, that produces one frame_edge after synchronisation.

## Timing
- readdata is updated every clock from the current address, regardless of chipselect. Read latency is 1 cycle.
- Register writes take effect at the same rising edge.
- vs_in to commit latency:
  - The boundary level is captured by s1 at edge N, and by s2 at edge N+1.
  - frame_edge is high during cycle N+1..N+2.
  - FRONT, fb_base, EVENT, FRAMES and the FSM update at edge N+2.
  - irq asserts at edge N+3.
- frame_edge lasts exactly one cycle per boundary, regardless of vsync pulse width.
- Pulses shorter than 2 clk periods are not guaranteed to be detected.

## Test plan
- Reset, then read 0–5 -> BUF0=0, BUF1=0x0004B000, CTRL=0, STATUS=0, EVENT=0, FRAMES=0; fb_base=0; irq=0.
- Write BUF1=0x00100000, write CTRL=1, read STATUS -> 0x2 (PENDING). Drive a vs_in falling edge -> at edge N+2: fb_base=0x00100000, STATUS.FRONT=1, EVENT=0x3. A second FLIP/edge pair -> fb_base=0.
- Write CTRL=0x2 (IRQ_EN), give one vsync -> irq=1 at N+3. Write EVENT=0x1 -> irq=0 on the next clock. W1C timed in the frame_edge cycle -> EVENT.FRAME stays 1.
- FLIP write in the exact frame_edge cycle -> no swap at that edge; swap at the following edge. Two FLIP writes before one edge -> one swap only.
- Preload FRAMES to 0xFFFFFFFF by driving 2^32-1 pulses (or via a forced-counter testbench hook) -> the next edge gives 0. A FRAMES write coinciding with an edge -> reads 0.
- Assert reset while PENDING, with vs_in held low (asserted) -> after release, PENDING=0, fb_base=BUF0_RESET, one FRAME event and no flip.
